// File: rtl/rename_pkg.sv
// Shared rename-stage types, used by the free list, the RAT and the ROB.
// Holds the architectural and physical register index widths and the typedefs
// built from them.
package rename_pkg;

    localparam int ARCH_REG_WIDTH = 3;
    localparam int PHYS_REG_WIDTH = 4;

    localparam int NUM_ARCH_REGS_DEFAULT = 1 << ARCH_REG_WIDTH;
    localparam int NUM_PHYS_REGS_DEFAULT = 1 << PHYS_REG_WIDTH;

    typedef logic [ARCH_REG_WIDTH-1:0] areg_t;
    typedef logic [PHYS_REG_WIDTH-1:0] preg_t;

endpackage

// File: rtl/circ_fifo.sv
// Circular FIFO with head/tail pointers, an occupancy count and storage that
// loads a caller-supplied pattern at reset.
// Ports:
//   clk        in   clock
//   rst        in   synchronous reset, active-high
//   push       in   write push_data at tail (caller guarantees not full)
//   push_data  in   WIDTH-bit entry
//   pop        in   advance head (caller guarantees not empty)
//   head_data  out  entry at head, combinational
//   count      out  number of valid entries
module circ_fifo #(
    parameter int DEPTH      = 16,
    parameter int WIDTH      = 4,
    parameter int INIT_COUNT = DEPTH,
    parameter logic [DEPTH*WIDTH-1:0] INIT_DATA = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head_data,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTRW      = $clog2(DEPTH);
    localparam int CW        = $clog2(DEPTH+1);
    localparam int INIT_TAIL = INIT_COUNT % DEPTH;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTRW-1:0]  head;
    logic [PTRW-1:0]  tail;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] ptr);
        return (ptr == PTRW'(DEPTH-1)) ? '0 : ptr + 1'b1;
    endfunction

    assign head_data = mem[head];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= PTRW'(INIT_TAIL);
            count <= CW'(INIT_COUNT);
            // NOTE: the storage is reset on purpose: the initial free-list
            // contents are architectural state, not don't-care data.
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= INIT_DATA[i*WIDTH +: WIDTH];
            end
        end else begin
            if (pop) begin
                head <= ptr_inc(head);
            end
            if (push) begin
                mem[tail] <= push_data;
                tail      <= ptr_inc(tail);
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/phys_reg_freelist.sv
// Free pool of physical registers. Rename pops pregs on the alloc port;
// commit returns each retired instruction's previous preg on the release
// port. A membership bitmap rejects releases of pregs that are already free
// or out of range and flags them in a sticky error bit.
// Ports:
//   clk              in   clock
//   rst              in   synchronous reset, active-high
//   alloc_req        in   rename wants one preg this cycle
//   alloc_valid      out  pool not empty
//   alloc_preg       out  preg at pool head (combinational)
//   rel_valid        in   commit returns one preg
//   rel_preg         in   preg being returned
//   rel_ready        out  pool not full
//   free_count       out  number of free pregs
//   err_double_free  out  sticky: a release was rejected
module phys_reg_freelist
    import rename_pkg::*;
#(
    parameter int NUM_ARCH_REGS = NUM_ARCH_REGS_DEFAULT,
    parameter int NUM_PHYS_REGS = NUM_PHYS_REGS_DEFAULT,
    parameter bit INIT_MAP      = 1'b0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             alloc_req,
    output logic                             alloc_valid,
    output logic [$clog2(NUM_PHYS_REGS)-1:0] alloc_preg,
    input  logic                             rel_valid,
    input  logic [$clog2(NUM_PHYS_REGS)-1:0] rel_preg,
    output logic                             rel_ready,
    output logic [$clog2(NUM_PHYS_REGS):0]   free_count,
    output logic                             err_double_free
);

    localparam int N          = NUM_PHYS_REGS;
    localparam int PW         = $clog2(N);
    localparam int INIT_COUNT = INIT_MAP ? N - NUM_ARCH_REGS : N;
    localparam logic [PW:0] N_CNT = (PW+1)'(N);

    // With INIT_MAP the architectural regs own pregs 0..NUM_ARCH_REGS-1, so
    // the pool starts at NUM_ARCH_REGS. Entries past the live count are never
    // read before being overwritten.
    function automatic logic [N*PW-1:0] build_init_data();
        logic [N*PW-1:0] v;
        v = '0;
        for (int i = 0; i < N; i++) begin
            v[i*PW +: PW] = PW'((INIT_MAP ? NUM_ARCH_REGS : 0) + i);
        end
        return v;
    endfunction

    function automatic logic [N-1:0] build_init_free();
        logic [N-1:0] m;
        for (int p = 0; p < N; p++) begin
            m[p] = !INIT_MAP || (p >= NUM_ARCH_REGS);
        end
        return m;
    endfunction

    localparam logic [N*PW-1:0] INIT_DATA = build_init_data();
    localparam logic [N-1:0]    INIT_FREE = build_init_free();

    logic [N-1:0] in_list;  // bit p set while preg p sits in the pool
    logic [PW:0]  count;
    logic         alloc_fire;
    logic         rel_in_range;
    logic         rel_bad;
    logic         rel_fire;

    assign alloc_valid  = (count != '0);
    assign rel_ready    = (count != N_CNT);
    assign free_count   = count;
    assign alloc_fire   = alloc_req && alloc_valid;

    // A full pool has every bitmap bit set, so any release there is rel_bad
    // through in_list alone; rel_ready is not needed to catch it.
    assign rel_in_range = ({1'b0, rel_preg} < N_CNT);
    assign rel_bad      = rel_valid && (!rel_in_range || in_list[rel_preg]);
    assign rel_fire     = rel_valid && rel_ready && !rel_bad;

    circ_fifo #(
        .DEPTH      (N),
        .WIDTH      (PW),
        .INIT_COUNT (INIT_COUNT),
        .INIT_DATA  (INIT_DATA)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (rel_fire),
        .push_data (rel_preg),
        .pop       (alloc_fire),
        .head_data (alloc_preg),
        .count     (count)
    );

    // The allocated preg has its bit set and a fired release has its bit
    // clear, so the two updates never target the same bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_list         <= INIT_FREE;
            err_double_free <= 1'b0;
        end else begin
            if (alloc_fire) begin
                in_list[alloc_preg] <= 1'b0;
            end
            if (rel_fire) begin
                in_list[rel_preg] <= 1'b1;
            end
            if (rel_bad) begin
                err_double_free <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_phys_reg_freelist.sv
module tb_phys_reg_freelist;
    import rename_pkg::*;

    localparam int N  = 16;
    localparam int NA = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DUT with all pregs free at reset
    logic        rst, alloc_req, rel_valid;
    logic [3:0]  rel_preg, alloc_preg;
    logic        alloc_valid, rel_ready, err;
    logic [4:0]  free_count;

    // DUT with the architectural pregs mapped at reset
    logic        rst_m, alloc_req_m, rel_valid_m;
    logic [3:0]  rel_preg_m, alloc_preg_m;
    logic        alloc_valid_m, rel_ready_m, err_m;
    logic [4:0]  free_count_m;

    phys_reg_freelist #(.NUM_ARCH_REGS(NA), .NUM_PHYS_REGS(N), .INIT_MAP(1'b0)) dut0 (
        .clk(clk), .rst(rst), .alloc_req(alloc_req), .alloc_valid(alloc_valid),
        .alloc_preg(alloc_preg), .rel_valid(rel_valid), .rel_preg(rel_preg),
        .rel_ready(rel_ready), .free_count(free_count), .err_double_free(err)
    );

    phys_reg_freelist #(.NUM_ARCH_REGS(NA), .NUM_PHYS_REGS(N), .INIT_MAP(1'b1)) dut1 (
        .clk(clk), .rst(rst_m), .alloc_req(alloc_req_m), .alloc_valid(alloc_valid_m),
        .alloc_preg(alloc_preg_m), .rel_valid(rel_valid_m), .rel_preg(rel_preg_m),
        .rel_ready(rel_ready_m), .free_count(free_count_m), .err_double_free(err_m)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic a, input logic v, input logic [3:0] p);
        alloc_req = a;
        rel_valid = v;
        rel_preg  = p;
        #1;
    endtask

    task automatic drive_m(input logic a, input logic v, input logic [3:0] p);
        alloc_req_m = a;
        rel_valid_m = v;
        rel_preg_m  = p;
        #1;
    endtask

    // Reference model: an ordered queue of free pregs plus a free flag per preg.
    int freeq[$];
    bit is_free [N];
    bit m_err;

    task automatic m_reset();
        freeq.delete();
        for (int i = 0; i < N; i++) begin
            freeq.push_back(i);
            is_free[i] = 1'b1;
        end
        m_err = 1'b0;
    endtask

    task automatic m_step(input bit a, input bit v, input int p);
        bit alloc_ok, bad, rel_ok;
        int x;
        alloc_ok = a && (freeq.size() != 0);
        bad      = v && ((p >= N) || is_free[p]);
        rel_ok   = v && (freeq.size() != N) && !bad;
        if (bad) m_err = 1'b1;
        if (alloc_ok) begin
            x = freeq.pop_front();
            is_free[x] = 1'b0;
        end
        if (rel_ok) begin
            freeq.push_back(p);
            is_free[p] = 1'b1;
        end
    endtask

    task automatic check_vs_model(input string tag);
        check({tag, ".alloc_valid"}, alloc_valid, freeq.size() != 0);
        if (freeq.size() != 0) check({tag, ".alloc_preg"}, alloc_preg, freeq[0]);
        check({tag, ".free_count"}, free_count, freeq.size());
        check({tag, ".rel_ready"}, rel_ready, freeq.size() != N);
        check({tag, ".err"}, err, m_err);
    endtask

    typedef struct {
        logic       a;
        logic       rv;
        logic [3:0] rp;
        logic       chk_preg;
        logic       e_valid;
        logic [3:0] e_preg;
        logic [4:0] e_count;
        logic       e_ready;
        logic       e_err;
    } vec_t;

    function automatic vec_t mk(input logic a, input logic rv, input logic [3:0] rp,
                                input logic cp, input logic ev, input logic [3:0] ep,
                                input logic [4:0] ec, input logic er, input logic ee);
        vec_t v;
        v.a = a; v.rv = rv; v.rp = rp; v.chk_preg = cp; v.e_valid = ev;
        v.e_preg = ep; v.e_count = ec; v.e_ready = er; v.e_err = ee;
        return v;
    endfunction

    localparam int NV = 23;
    vec_t vecs [NV];

    initial begin
        int prev, nxt, rp;
        bit a, v;
        int used[$];

        // Expected values are the outputs seen with the vector's inputs
        // applied, before the clock edge that consumes them.
        for (int i = 0; i < 16; i++) begin
            vecs[i] = mk(1, 0, 0, 1, 1, 4'(i), 5'(16 - i), i != 0, 0);
        end
        vecs[16] = mk(1, 1, 5, 0, 0, 0, 0, 1, 0);  // empty: same-cycle release, no bypass
        vecs[17] = mk(0, 0, 0, 1, 1, 5, 1, 1, 0);  // released preg now at head
        vecs[18] = mk(0, 1, 2, 1, 1, 5, 1, 1, 0);  // legal release of 2
        vecs[19] = mk(0, 1, 2, 1, 1, 5, 2, 1, 0);  // 2 already free: double free
        vecs[20] = mk(0, 1, 5, 1, 1, 5, 2, 1, 1);  // 5 already free
        vecs[21] = mk(1, 1, 5, 1, 1, 5, 2, 1, 1);  // release the preg being allocated
        vecs[22] = mk(0, 0, 0, 1, 1, 2, 1, 1, 1);  // only the alloc took effect

        rst = 1'b1; rst_m = 1'b1;
        drive(0, 0, 0);
        drive_m(0, 0, 0);
        tick();
        tick();
        rst = 1'b0; rst_m = 1'b0;

        // Table-driven directed sequence
        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].a, vecs[i].rv, vecs[i].rp);
            check($sformatf("vec%0d.alloc_valid", i), alloc_valid, vecs[i].e_valid);
            if (vecs[i].chk_preg) check($sformatf("vec%0d.alloc_preg", i), alloc_preg, vecs[i].e_preg);
            check($sformatf("vec%0d.free_count", i), free_count, vecs[i].e_count);
            check($sformatf("vec%0d.rel_ready", i), rel_ready, vecs[i].e_ready);
            check($sformatf("vec%0d.err", i), err, vecs[i].e_err);
            tick();
        end

        // Reset wins over same-cycle alloc and release, and clears the error
        drive(1, 1, 3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(0, 0, 0);
        check("rst_override.free_count", free_count, 16);
        check("rst_override.err", err, 0);
        check("rst_override.alloc_preg", alloc_preg, 0);
        check("rst_override.alloc_valid", alloc_valid, 1);

        // Full pool: release is rejected as a duplicate
        drive(0, 1, 3);
        check("full.rel_ready", rel_ready, 0);
        tick();
        drive(0, 0, 0);
        check("full.err", err, 1);
        check("full.free_count", free_count, 16);

        // Mapped reset pattern, then preg 3 returns after 8..15
        check("map.free_count", free_count_m, 8);
        check("map.alloc_preg", alloc_preg_m, 8);
        check("map.err", err_m, 0);
        drive_m(0, 1, 3);
        tick();
        drive_m(0, 0, 0);
        check("map.count_after_rel", free_count_m, 9);
        for (int k = 0; k < 9; k++) begin
            drive_m(1, 0, 0);
            check($sformatf("map.order%0d", k), alloc_preg_m, (k < 8) ? 8 + k : 3);
            tick();
        end
        drive_m(0, 0, 0);
        check("map.empty_valid", alloc_valid_m, 0);
        check("map.empty_count", free_count_m, 0);

        // Steady state at count 4 with pointers wrapping
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_reset();
        for (int k = 0; k < 12; k++) begin
            drive(1, 0, 0);
            check_vs_model($sformatf("fill%0d", k));
            m_step(1, 0, 0);
            tick();
        end
        prev = 11;
        for (int k = 0; k < 20; k++) begin
            drive(1, 1, 4'(prev));
            check_vs_model($sformatf("steady%0d", k));
            check($sformatf("steady%0d.count4", k), free_count, 4);
            nxt = freeq[0];
            m_step(1, 1, prev);
            prev = nxt;
            tick();
        end

        // Randomized traffic against the model; occasional stray releases
        rst = 1'b1;
        drive(0, 0, 0);
        tick();
        rst = 1'b0;
        m_reset();
        for (int c = 0; c < 10000; c++) begin
            used.delete();
            for (int p = 0; p < N; p++) if (!is_free[p]) used.push_back(p);
            a = ($urandom_range(0, 3) != 0);
            v = ($urandom_range(0, 2) != 0);
            if (c >= 5000 && $urandom_range(0, 63) == 0) begin
                rp = $urandom_range(0, N - 1);
            end else if (used.size() != 0) begin
                rp = used[$urandom_range(0, used.size() - 1)];
            end else begin
                rp = 0;
                v  = 1'b0;
            end
            drive(a, v, 4'(rp));
            check_vs_model($sformatf("rand%0d", c));
            if (a && freeq.size() != 0) check($sformatf("rand%0d.no_dup", c), is_free[alloc_preg], 1);
            m_step(a, v, rp);
            tick();
        end
        drive(0, 0, 0);
        check_vs_model("rand_end");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
